video_timing_controller: RTL and testbench
==========================================

// Module: video_timing_controller
// PURPOSE
//  Sequences the HDMI TX pixel datapath: raster counters, sync/DE timing and pixel colour for the
//  TMDS encoder, selected by the 4-bit mode input. Supersedes the free-running DE/colour logic in
//  image_output and drives the encoder directly.
//  Mode changes take effect only at a frame boundary, so the sink never sees a torn frame.
// PARAMETERS
//  DEFAULT_MODE  0   mode table index loaded at reset
//  CNT_W         12  width of h/v counters and x/y outputs (fits 2200 total)
// PORTS
//  pixel_clock   in   1      pixel clock; frequency supplied externally to match active mode
//  reset_n       in   1      asynchronous active-low reset
//  mode          in   4      requested mode: 0=640x480, 1=1280x720, 2=1920x1080, others invalid
//  data_enable   out  1      active-video qualifier
//  horz_sync     out  1      HSYNC, polarity per mode
//  vert_sync     out  1      VSYNC, polarity per mode
//  red/green/blue out 8 each pixel colour; 0 outside active video
//  pixel_x       out  CNT_W  active-area x (0 when !data_enable)
//  pixel_y       out  CNT_W  active-area y (0 when !data_enable)
//  frame_start   out  1      1-cycle pulse with first active pixel of a frame (x=0, y=0)
//  mode_active   out  4      mode currently being rasterised
//  mode_error    out  1      sticky: set when an invalid mode is sampled, cleared by a valid sample
// BEHAVIOUR
//  - Timing (h: active/fp/sync/bp/total; v: same; sync polarity):
//    mode0 640/16/96/48/800, 480/10/2/33/525, negative; mode1 1280/110/40/220/1650,
//    720/5/5/20/750, positive; mode2 1920/88/44/148/2200, 1080/4/5/36/1125, positive.
//  - Counter ordering: active, front porch, sync, back porch. h_cnt 0..H_TOTAL-1 wraps to 0
//    and increments v_cnt; v_cnt 0..V_TOTAL-1 wraps to 0.
//  - Sync asserted while active_w+fp_w <= cnt < active_w+fp_w+sync_w; VSYNC uses v_cnt only.
//  - Outputs are decoded from the counters and registered: exactly 1 cycle latency from counter
//    state to data_enable/syncs/colour/pixel_x/pixel_y/frame_start. All outputs stay aligned.
//  - Mode sampling at the last pixel of a frame (h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1):
//    - valid mode: becomes mode_active from the next cycle (counters at 0,0) and clears mode_error;
//    - invalid mode: mode_active holds and mode_error sets.
//    mode is ignored mid-frame.
//  - Mode switch: both counters restart at 0 with the new table. No partial line is emitted.
//  - Reset (async assert, sync deassert is the system's job): counters 0, mode_active=DEFAULT_MODE,
//    mode_error=0, data_enable=0, colour=0, pixel_x/y=0, frame_start=0.
//    Syncs reset to their inactive level for DEFAULT_MODE: high for negative polarity, low for
//    positive.
//  - Reset mid-frame aborts the raster. After release, the first cycle restarts at (0,0), so
//    frame_start pulses 1 cycle after the first post-reset edge.
// CONFIGURATION
//  Macro TEST_PATTERN_EN:
//   - defined: 8 vertical colour bars during DE, each active_w/8 pixels wide, left to right
//     white, yellow, cyan, green, magenta, red, blue, black (components 8'hFF/8'h00). Bar index is
//     derived from pixel_x by compare against per-mode constants; no divider.
//   - undefined: {red,green,blue}=24'hFFFFFF during DE, 0 otherwise.
// STRUCTURE
//  Package video_timing_pkg:
//   - typedef timing_t {h_active,h_fp,h_sync,h_bp,h_total,v_active,v_fp,v_sync,v_bp,v_total,
//     sync_pol}
//   - localparam timing_t MODE_TABLE[3]
//   - mode index constants MODE_640X480, MODE_1280X720, MODE_1920X1080
//   - colour-bar RGB constants
//  Sub-module raster_counter: h/v counters with wrap and an end-of-frame flag; the controller owns
//  mode latching and output decode.
// TESTING
//  1 reset, mode=0, run 800*525 cycles -> data_enable high 640 cycles/line on 480 lines;
//    HSYNC low 96 cycles starting 656 cycles after DE rise.
//  2 mode=0, 2 frames -> frame_start period exactly 420000 cycles; VSYNC low exactly 2 lines
//    (1600 cycles).
//  3 mode changed 0->1 mid-frame -> mode_active stays 0 until end of frame; next frame 1650x750
//    with positive syncs; first line DE=1280.
//  4 mode=4'hF at frame end -> mode_error=1, mode_active unchanged, raster unchanged; then mode=2
//    -> mode_error clears at next frame end and the 2200x1125 raster starts.
//  5 reset_n pulsed low mid-line, mode=1 active -> all outputs at reset values immediately and
//    mode_active=DEFAULT_MODE; raster restarts at (0,0).
//  6 TEST_PATTERN_EN, mode=0 -> x=0..79 RGB=FFFFFF, x=80 RGB=FFFF00, x=560..639 RGB=000000;
//    without macro -> FFFFFF across all 640 pixels.

Source files
------------

// File: rtl/video_timing_pkg.sv
// video_timing_pkg: mode timing table, mode indices, colour-bar constants and mode validity helper
package video_timing_pkg;
  localparam int TW = 12;
  typedef struct packed {
    logic [TW-1:0] h_active, h_fp, h_sync, h_bp, h_total;
    logic [TW-1:0] v_active, v_fp, v_sync, v_bp, v_total;
    logic          sync_pol;
  } timing_t;
  localparam logic [3:0] MODE_640X480 = 4'd0, MODE_1280X720 = 4'd1, MODE_1920X1080 = 4'd2;
  localparam timing_t MODE_TABLE [3] = '{
    '{12'd640, 12'd16, 12'd96, 12'd48, 12'd800, 12'd480, 12'd10, 12'd2, 12'd33, 12'd525, 1'b0},
    '{12'd1280, 12'd110, 12'd40, 12'd220, 12'd1650, 12'd720, 12'd5, 12'd5, 12'd20, 12'd750, 1'b1},
    '{12'd1920, 12'd88, 12'd44, 12'd148, 12'd2200, 12'd1080, 12'd4, 12'd5, 12'd36, 12'd1125, 1'b1}
  };
  localparam logic [23:0] RGB_WHITE = 24'hFFFFFF, RGB_YELLOW = 24'hFFFF00, RGB_CYAN = 24'h00FFFF,
                          RGB_GREEN = 24'h00FF00, RGB_MAGENTA = 24'hFF00FF, RGB_RED = 24'hFF0000,
                          RGB_BLUE = 24'h0000FF, RGB_BLACK = 24'h000000;
  localparam logic [7:0][23:0] BAR_RGB = {RGB_BLACK, RGB_BLUE, RGB_RED, RGB_MAGENTA,
                                          RGB_GREEN, RGB_CYAN, RGB_YELLOW, RGB_WHITE};
  function automatic logic mode_valid(input logic [3:0] m);
    return m <= MODE_1920X1080;
  endfunction
endpackage

// File: rtl/video_timing_controller_if.sv
// video_timing_controller_if: mode request in, raster timing/colour out; master = controller, slave = sink
interface video_timing_controller_if #(parameter int CNT_W = 12);
  logic [3:0]       mode;
  logic             data_enable, horz_sync, vert_sync, frame_start, mode_error;
  logic [7:0]       red, green, blue;
  logic [CNT_W-1:0] pixel_x, pixel_y;
  logic [3:0]       mode_active;
  modport master (input mode, output data_enable, horz_sync, vert_sync, red, green, blue,
                  pixel_x, pixel_y, frame_start, mode_active, mode_error);
  modport slave (output mode, input data_enable, horz_sync, vert_sync, red, green, blue,
                 pixel_x, pixel_y, frame_start, mode_active, mode_error);
endinterface

// File: rtl/video_timing_controller_raster_counter.sv
// raster_counter: h/v raster counters wrapping at the given totals, with end-of-frame flag
//   clk_i, rst_ni          clock, async active-low reset
//   h_total_i, v_total_i   totals of the mode being rasterised
//   h_cnt_o, v_cnt_o       current raster position
//   eof_o                  high on the last pixel of the frame
module raster_counter #(parameter int CNT_W = 12) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [CNT_W-1:0] h_total_i,
  input  logic [CNT_W-1:0] v_total_i,
  output logic [CNT_W-1:0] h_cnt_o,
  output logic [CNT_W-1:0] v_cnt_o,
  output logic             eof_o
);
  logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
  logic h_end;
  always_comb begin
    h_end = h_q == h_total_i - CNT_W'(1);
    eof_o = h_end && v_q == v_total_i - CNT_W'(1);
    h_d = h_end ? '0 : h_q + CNT_W'(1);
    v_d = eof_o ? '0 : h_end ? v_q + CNT_W'(1) : v_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  assign h_cnt_o = h_q;
  assign v_cnt_o = v_q;
endmodule

// File: rtl/video_timing_controller.sv
// video_timing_controller: HDMI TX raster timing, sync/DE decode and pixel colour per selected mode
//   pixel_clock, reset_n   pixel clock, async active-low reset
//   vif (master)           mode in; DE, syncs, RGB, pixel_x/y, frame_start, mode_active, mode_error out
//   TEST_PATTERN_EN        defined: 8 vertical colour bars during DE; undefined: white during DE
//   T0..T2                 timing of modes 0..2, normally the package table
module video_timing_controller import video_timing_pkg::*; #(
  parameter int      DEFAULT_MODE = 0,
  parameter int      CNT_W        = 12,
  parameter timing_t T0           = MODE_TABLE[0],
  parameter timing_t T1           = MODE_TABLE[1],
  parameter timing_t T2           = MODE_TABLE[2]
) (
  input logic pixel_clock,
  input logic reset_n,
  video_timing_controller_if.master vif
);
  // slot 3 is never selected since mode_q only holds valid modes
  localparam timing_t TT [4] = '{T0, T1, T2, T0};
  logic [CNT_W-1:0] h_cnt, v_cnt, x_q, y_q;
  logic [3:0] mode_q;
  logic [1:0] mi;
  logic eof, err_q, de_q, hs_q, vs_q, fs_q, de_d, hs_d, vs_d;
  logic [23:0] rgb_q, rgb_d;
  assign mi = mode_q[1:0];
  raster_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk_i    (pixel_clock),
    .rst_ni   (reset_n),
    .h_total_i(CNT_W'(TT[mi].h_total)),
    .v_total_i(CNT_W'(TT[mi].v_total)),
    .h_cnt_o  (h_cnt),
    .v_cnt_o  (v_cnt),
    .eof_o    (eof)
  );
  // sync level is the in-window flag XNOR polarity, so negative-polarity syncs idle high
  always_comb begin
    de_d = h_cnt < CNT_W'(TT[mi].h_active) && v_cnt < CNT_W'(TT[mi].v_active);
    hs_d = (h_cnt >= CNT_W'(TT[mi].h_active + TT[mi].h_fp) &&
            h_cnt < CNT_W'(TT[mi].h_active + TT[mi].h_fp + TT[mi].h_sync)) ~^ TT[mi].sync_pol;
    vs_d = (v_cnt >= CNT_W'(TT[mi].v_active + TT[mi].v_fp) &&
            v_cnt < CNT_W'(TT[mi].v_active + TT[mi].v_fp + TT[mi].v_sync)) ~^ TT[mi].sync_pol;
  end
`ifdef TEST_PATTERN_EN
  logic [2:0] bar;
  // bar index = number of bar boundaries (k * active/8) at or left of the pixel
  always_comb begin
    bar = 3'd0;
    for (int k = 1; k < 8; k++)
      if (h_cnt >= CNT_W'(k) * CNT_W'(TT[mi].h_active >> 3)) bar = 3'(k);
  end
  assign rgb_d = de_d ? BAR_RGB[bar] : 24'h0;
`else
  assign rgb_d = de_d ? RGB_WHITE : 24'h0;
`endif
  always_ff @(posedge pixel_clock or negedge reset_n)
    if (!reset_n) begin
      mode_q <= 4'(DEFAULT_MODE);
      err_q  <= 1'b0;
      de_q   <= 1'b0;
      hs_q   <= ~TT[DEFAULT_MODE].sync_pol;
      vs_q   <= ~TT[DEFAULT_MODE].sync_pol;
      rgb_q  <= '0;
      x_q    <= '0;
      y_q    <= '0;
      fs_q   <= 1'b0;
    end else begin
      if (eof) begin
        mode_q <= mode_valid(vif.mode) ? vif.mode : mode_q;
        err_q  <= !mode_valid(vif.mode);
      end
      de_q  <= de_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      rgb_q <= rgb_d;
      x_q   <= de_d ? h_cnt : '0;
      y_q   <= de_d ? v_cnt : '0;
      fs_q  <= h_cnt == '0 && v_cnt == '0;
    end
  assign vif.data_enable = de_q;
  assign vif.horz_sync   = hs_q;
  assign vif.vert_sync   = vs_q;
  assign {vif.red, vif.green, vif.blue} = rgb_q;
  assign vif.pixel_x     = x_q;
  assign vif.pixel_y     = y_q;
  assign vif.frame_start = fs_q;
  assign vif.mode_active = mode_q;
  assign vif.mode_error  = err_q;
endmodule

// File: tb/tb_video_timing_controller.sv
// tb_video_timing_controller: line timing on the real mode table, frame/mode behaviour on a shrunk table
module tb_video_timing_controller;
  import video_timing_pkg::*;
  localparam timing_t S0 = '{12'd16, 12'd2, 12'd3, 12'd2, 12'd23, 12'd4, 12'd1, 12'd2, 12'd1, 12'd8, 1'b0};
  localparam timing_t S1 = '{12'd24, 12'd1, 12'd2, 12'd1, 12'd28, 12'd3, 12'd1, 12'd1, 12'd1, 12'd6, 1'b1};
  localparam timing_t S2 = '{12'd32, 12'd2, 12'd2, 12'd2, 12'd38, 12'd5, 12'd1, 12'd1, 12'd1, 12'd8, 1'b1};
`ifdef TEST_PATTERN_EN
  localparam int TP = 1;
`else
  localparam int TP = 0;
`endif
  typedef struct {int k, m, de, hs, vs, fs, x, y, ma, err, rd, rt;} vec_t;
  logic clk = 1'b0, rst_r_n = 1'b0, rst_s_n = 1'b0;
  int checks = 0, errors = 0, edges = 0;
  vec_t vq[$];
  always #5 clk = ~clk;
  video_timing_controller_if if_r ();
  video_timing_controller_if if_s ();
  video_timing_controller dut_r (.pixel_clock(clk), .reset_n(rst_r_n), .vif(if_r));
  video_timing_controller #(.T0(S0), .T1(S1), .T2(S2)) dut_s (.pixel_clock(clk), .reset_n(rst_s_n), .vif(if_s));
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    edges++;
  endtask
  task automatic chk_rst(input string p, input int de, hs, vs, fs, x, y, rgb, ma, err);
    chk({p, " de"}, de, 0);
    chk({p, " hs"}, hs, 1);
    chk({p, " vs"}, vs, 1);
    chk({p, " fs"}, fs, 0);
    chk({p, " x"}, x, 0);
    chk({p, " y"}, y, 0);
    chk({p, " rgb"}, rgb, 0);
    chk({p, " mode_active"}, ma, 0);
    chk({p, " mode_error"}, err, 0);
  endtask
  function automatic vec_t mk(int k, m, de, hs, vs, fs, x, y, ma, err, rd, rt);
    vec_t v = '{k, m, de, hs, vs, fs, x, y, ma, err, rd, rt};
    return v;
  endfunction
  initial begin
    int de_cnt[3], hs_low[3], rise_c[3], fall_c[3];
    int fs_cnt, vs_low, p, h, l, prev_de, prev_hs;
    fs_cnt = 0; vs_low = 0; prev_de = 0; prev_hs = 1;
    for (int i = 0; i < 3; i++) begin
      de_cnt[i] = 0; hs_low[i] = 0; rise_c[i] = -1; fall_c[i] = -1;
    end
    // k, mode, de, hs, vs, fs, x, y, mode_active, mode_error, rgb (white build), rgb (bar build)
    vq.push_back(mk(1, 0, 1, 1, 1, 1, 0, 0, 0, 0, 'hFFFFFF, 'hFFFFFF));
    vq.push_back(mk(2, 0, 1, 1, 1, 0, 1, 0, 0, 0, 'hFFFFFF, 'hFFFFFF));
    vq.push_back(mk(3, 0, 1, 1, 1, 0, 2, 0, 0, 0, 'hFFFFFF, 'hFFFF00));
    vq.push_back(mk(16, 0, 1, 1, 1, 0, 15, 0, 0, 0, 'hFFFFFF, 'h000000));
    vq.push_back(mk(17, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(19, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(21, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(22, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(24, 0, 1, 1, 1, 0, 0, 1, 0, 0, 'hFFFFFF, 'hFFFFFF));
    vq.push_back(mk(93, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(100, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(116, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(139, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(162, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(184, 1, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0));
    vq.push_back(mk(185, 1, 1, 0, 0, 1, 0, 0, 1, 0, 'hFFFFFF, 'hFFFFFF));
    vq.push_back(mk(188, 1, 1, 0, 0, 0, 3, 0, 1, 0, 'hFFFFFF, 'hFFFF00));
    vq.push_back(mk(208, 1, 1, 0, 0, 0, 23, 0, 1, 0, 'hFFFFFF, 'h000000));
    vq.push_back(mk(209, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    vq.push_back(mk(210, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0));
    vq.push_back(mk(212, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    vq.push_back(mk(213, 1, 1, 0, 0, 0, 0, 1, 1, 0, 'hFFFFFF, 'hFFFFFF));
    vq.push_back(mk(297, 1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0));
    vq.push_back(mk(325, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    vq.push_back(mk(352, 15, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    vq.push_back(mk(353, 15, 1, 0, 0, 1, 0, 0, 1, 1, 'hFFFFFF, 'hFFFFFF));
    vq.push_back(mk(400, 2, 1, 0, 0, 0, 19, 1, 1, 1, 'hFFFFFF, 'h0000FF));
    vq.push_back(mk(520, 2, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0));
    vq.push_back(mk(521, 2, 1, 0, 0, 1, 0, 0, 2, 0, 'hFFFFFF, 'hFFFFFF));
    vq.push_back(mk(525, 2, 1, 0, 0, 0, 4, 0, 2, 0, 'hFFFFFF, 'hFFFF00));
    vq.push_back(mk(552, 2, 1, 0, 0, 0, 31, 0, 2, 0, 'hFFFFFF, 'h000000));
    vq.push_back(mk(553, 2, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0));
    vq.push_back(mk(555, 2, 0, 1, 0, 0, 0, 0, 2, 0, 0, 0));
    vq.push_back(mk(557, 2, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0));
    vq.push_back(mk(559, 2, 1, 0, 0, 0, 0, 1, 2, 0, 'hFFFFFF, 'hFFFFFF));
    if_r.mode = 4'd0;
    if_s.mode = 4'd0;
    step();
    step();
    chk_rst("r_reset", int'(if_r.data_enable), int'(if_r.horz_sync), int'(if_r.vert_sync),
            int'(if_r.frame_start), int'(if_r.pixel_x), int'(if_r.pixel_y),
            int'({if_r.red, if_r.green, if_r.blue}), int'(if_r.mode_active), int'(if_r.mode_error));
    rst_r_n = 1'b1;
    for (int c = 1; c <= 2400; c++) begin
      step();
      p = c - 1;
      h = p % 800;
      l = p / 800;
      de_cnt[l] += int'(if_r.data_enable);
      if (!if_r.horz_sync) hs_low[l]++;
      if (!if_r.vert_sync) vs_low++;
      fs_cnt += int'(if_r.frame_start);
      if (prev_de == 0 && if_r.data_enable) rise_c[l] = c;
      if (prev_hs == 1 && !if_r.horz_sync) fall_c[l] = c;
      prev_de = int'(if_r.data_enable);
      prev_hs = int'(if_r.horz_sync);
      if (l == 0 && (h == 0 || h == 80 || h == 560 || h == 639)) begin
        chk($sformatf("r x at h%0d", h), int'(if_r.pixel_x), h);
        chk($sformatf("r rgb at h%0d", h), int'({if_r.red, if_r.green, if_r.blue}),
            TP == 0 ? 'hFFFFFF : h == 0 ? 'hFFFFFF : h == 80 ? 'hFFFF00 : 0);
      end
      if (l == 1 && h == 5) begin
        chk("r y line1", int'(if_r.pixel_y), 1);
        chk("r x line1", int'(if_r.pixel_x), 5);
      end
    end
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("r de count line%0d", i), de_cnt[i], 640);
      chk($sformatf("r hsync low line%0d", i), hs_low[i], 96);
      chk($sformatf("r hsync fall after de rise line%0d", i), fall_c[i] - rise_c[i], 656);
    end
    chk("r frame_start count", fs_cnt, 1);
    chk("r vsync low in first lines", vs_low, 0);
    chk_rst("s_reset", int'(if_s.data_enable), int'(if_s.horz_sync), int'(if_s.vert_sync),
            int'(if_s.frame_start), int'(if_s.pixel_x), int'(if_s.pixel_y),
            int'({if_s.red, if_s.green, if_s.blue}), int'(if_s.mode_active), int'(if_s.mode_error));
    rst_s_n = 1'b1;
    edges = 0;
    foreach (vq[i]) begin
      if_s.mode = 4'(vq[i].m);
      while (edges < vq[i].k) step();
      chk($sformatf("k%0d de", vq[i].k), int'(if_s.data_enable), vq[i].de);
      chk($sformatf("k%0d hsync", vq[i].k), int'(if_s.horz_sync), vq[i].hs);
      chk($sformatf("k%0d vsync", vq[i].k), int'(if_s.vert_sync), vq[i].vs);
      chk($sformatf("k%0d frame_start", vq[i].k), int'(if_s.frame_start), vq[i].fs);
      chk($sformatf("k%0d pixel_x", vq[i].k), int'(if_s.pixel_x), vq[i].x);
      chk($sformatf("k%0d pixel_y", vq[i].k), int'(if_s.pixel_y), vq[i].y);
      chk($sformatf("k%0d mode_active", vq[i].k), int'(if_s.mode_active), vq[i].ma);
      chk($sformatf("k%0d mode_error", vq[i].k), int'(if_s.mode_error), vq[i].err);
      chk($sformatf("k%0d rgb", vq[i].k), int'({if_s.red, if_s.green, if_s.blue}),
          TP == 0 ? vq[i].rd : vq[i].rt);
    end
    if_s.mode = 4'd1;
    for (int n = 0; n < 400 && if_s.mode_active != 4'd1; n++) step();
    chk("t5 mode1 active", int'(if_s.mode_active), 1);
    chk("t5 switch edge", edges, 824);
    repeat (5) step();
    chk("t5 mid-line de", int'(if_s.data_enable), 1);
    chk("t5 mid-line x", int'(if_s.pixel_x), 4);
    rst_s_n = 1'b0;
    #1;
    chk_rst("t5 async reset", int'(if_s.data_enable), int'(if_s.horz_sync), int'(if_s.vert_sync),
            int'(if_s.frame_start), int'(if_s.pixel_x), int'(if_s.pixel_y),
            int'({if_s.red, if_s.green, if_s.blue}), int'(if_s.mode_active), int'(if_s.mode_error));
    step();
    step();
    chk("t5 held reset de", int'(if_s.data_enable), 0);
    rst_s_n = 1'b1;
    step();
    chk("t5 restart frame_start", int'(if_s.frame_start), 1);
    chk("t5 restart de", int'(if_s.data_enable), 1);
    chk("t5 restart x", int'(if_s.pixel_x), 0);
    chk("t5 restart y", int'(if_s.pixel_y), 0);
    chk("t5 restart hsync", int'(if_s.horz_sync), 1);
    chk("t5 restart mode_active", int'(if_s.mode_active), 0);
    step();
    chk("t5 second x", int'(if_s.pixel_x), 1);
    chk("t5 second frame_start", int'(if_s.frame_start), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
